// File: rtl/codec_ctrl.sv
// codec_ctrl: WM8731 bring-up and run-time volume sequencer.
//   Walks a fixed table of codec register writes through the shared I2C
//   master, then enables audio streaming and turns volume key pulses into
//   single headphone-volume register writes.
//
// Ports
//   i_clk        12 MHz system clock
//   i_rst        asynchronous reset, active high
//   i_start      level; a sampled rising edge starts or restarts init
//   i_vol_up     one-cycle pulse: raise volume by one step
//   i_vol_dn     one-cycle pulse: lower volume by one step
//   i_i2c_done   one-cycle pulse: current I2C write finished
//   o_i2c_enb    write request, held high until i_i2c_done
//   o_addr       codec register address of the current write
//   o_data       codec register data of the current write
//   o_lcr_enb    audio streaming enable
//   o_busy       high in every state except IDLE, RUN and ERR
//   o_err        sticky I2C timeout flag
//   o_vol        current headphone volume code
//
// state | meaning
// IDLE  | waiting for the first start edge
// REQ   | init-table write in flight
// GAP   | quiet time after an init write
// RUN   | streaming; servicing volume requests
// VREQ  | volume write in flight
// VGAP  | quiet time after a volume write
// ERR   | I2C timeout; waiting for a start edge
module codec_ctrl #(
    parameter int         N_INIT      = 8,
    parameter logic [6:0] VOL_DEFAULT = 7'h79,
    parameter logic [6:0] VOL_MIN     = 7'h30,
    parameter logic [6:0] VOL_MAX     = 7'h7F,
    parameter int         VOL_STEP    = 4,
    parameter int         GAP_CYCLES  = 16,
    parameter int         TIMEOUT     = 4095
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_vol_up,
    input  logic       i_vol_dn,
    input  logic       i_i2c_done,
    output logic       o_i2c_enb,
    output logic [6:0] o_addr,
    output logic [8:0] o_data,
    output logic       o_lcr_enb,
    output logic       o_busy,
    output logic       o_err,
    output logic [6:0] o_vol
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, REQ, GAP, RUN, VREQ, VGAP, ERR} state_t;

    state_t        state;
    logic          start_q;
    logic [2:0]    idx;
    logic [TW-1:0] tmr;
    logic [GW-1:0] gap_cnt;
    logic          pend_up, pend_dn, restart_pend;

    logic          start_rise, req_up, req_dn, vol_take;
    logic          pu_nxt, pd_nxt;
    logic [7:0]    vol_sum, vol_diff;
    logic [6:0]    vol_new;

    function automatic logic [15:0] init_entry(input logic [2:0] i, input logic [6:0] v);
        case (i)
            3'd0:    init_entry = {7'd15, 9'h000};
            3'd1:    init_entry = {7'd6,  9'h010};
            3'd2:    init_entry = {7'd4,  9'h012};
            3'd3:    init_entry = {7'd5,  9'h000};
            3'd4:    init_entry = {7'd7,  9'h002};
            3'd5:    init_entry = {7'd8,  9'h001};
            3'd6:    init_entry = {7'd2,  2'b10, v};
            default: init_entry = {7'd9,  9'h001};
        endcase
    endfunction

    assign start_rise = i_start & ~start_q;
    // Simultaneous up and down cancel before they reach the pending flags.
    assign req_up     = i_vol_up & ~i_vol_dn;
    assign req_dn     = i_vol_dn & ~i_vol_up;
    // A restart edge in RUN wins; the pending step is kept for after re-init.
    assign vol_take   = (state == RUN) && (pend_up || pend_dn) && !start_rise;

    always_comb begin
        vol_sum  = {1'b0, o_vol} + 8'(VOL_STEP);
        vol_diff = {1'b0, o_vol} - 8'(VOL_STEP);
        vol_new  = o_vol;
        if (pend_up)
            vol_new = (vol_sum > {1'b0, VOL_MAX}) ? VOL_MAX : vol_sum[6:0];
        else if (pend_dn)
            vol_new = (vol_diff[7] || vol_diff < {1'b0, VOL_MIN}) ? VOL_MIN : vol_diff[6:0];
    end

    // One pending direction at most; an opposite request cancels it.
    always_comb begin
        pu_nxt = pend_up & ~vol_take;
        pd_nxt = pend_dn & ~vol_take;
        if (req_up) begin
            if (pd_nxt) pd_nxt = 1'b0;
            else        pu_nxt = 1'b1;
        end else if (req_dn) begin
            if (pu_nxt) pu_nxt = 1'b0;
            else        pd_nxt = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= IDLE;
            start_q      <= 1'b0;
            idx          <= '0;
            tmr          <= '0;
            gap_cnt      <= '0;
            pend_up      <= 1'b0;
            pend_dn      <= 1'b0;
            restart_pend <= 1'b0;
            o_i2c_enb    <= 1'b0;
            o_addr       <= '0;
            o_data       <= '0;
            o_lcr_enb    <= 1'b0;
            o_busy       <= 1'b0;
            o_err        <= 1'b0;
            o_vol        <= VOL_DEFAULT;
        end else begin
            start_q <= i_start;
            pend_up <= pu_nxt;
            pend_dn <= pd_nxt;
            case (state)
                IDLE, ERR: begin
                    if (start_rise) begin
                        state              <= REQ;
                        idx                <= '0;
                        {o_addr, o_data}   <= init_entry(3'd0, o_vol);
                        tmr                <= TW'(TIMEOUT - 1);
                        o_i2c_enb          <= 1'b1;
                        o_busy             <= 1'b1;
                        o_err              <= 1'b0;
                    end
                end
                REQ, VREQ: begin
                    if (state == VREQ && start_rise) begin
                        restart_pend <= 1'b1;
                        o_lcr_enb    <= 1'b0;
                    end
                    if (i_i2c_done) begin
                        state     <= (state == REQ) ? GAP : VGAP;
                        gap_cnt   <= GW'(GAP_CYCLES - 1);
                        o_i2c_enb <= 1'b0;
                    end else if (tmr == '0) begin
                        state        <= ERR;
                        restart_pend <= 1'b0;
                        o_i2c_enb    <= 1'b0;
                        o_lcr_enb    <= 1'b0;
                        o_busy       <= 1'b0;
                        o_err        <= 1'b1;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (idx == 3'(N_INIT - 1)) begin
                        state     <= RUN;
                        o_lcr_enb <= 1'b1;
                        o_busy    <= 1'b0;
                    end else begin
                        state            <= REQ;
                        idx              <= idx + 1'b1;
                        {o_addr, o_data} <= init_entry(idx + 1'b1, o_vol);
                        tmr              <= TW'(TIMEOUT - 1);
                        o_i2c_enb        <= 1'b1;
                    end
                end
                RUN: begin
                    if (start_rise) begin
                        state            <= REQ;
                        idx              <= '0;
                        {o_addr, o_data} <= init_entry(3'd0, o_vol);
                        tmr              <= TW'(TIMEOUT - 1);
                        o_i2c_enb        <= 1'b1;
                        o_lcr_enb        <= 1'b0;
                        o_busy           <= 1'b1;
                    end else if (vol_take && vol_new != o_vol) begin
                        state     <= VREQ;
                        o_vol     <= vol_new;
                        o_addr    <= 7'd2;
                        o_data    <= {2'b10, vol_new};
                        tmr       <= TW'(TIMEOUT - 1);
                        o_i2c_enb <= 1'b1;
                        o_busy    <= 1'b1;
                    end
                end
                VGAP: begin
                    if (start_rise) begin
                        restart_pend <= 1'b1;
                        o_lcr_enb    <= 1'b0;
                    end
                    if (gap_cnt != '0) begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end else if (restart_pend || start_rise) begin
                        state            <= REQ;
                        idx              <= '0;
                        {o_addr, o_data} <= init_entry(3'd0, o_vol);
                        tmr              <= TW'(TIMEOUT - 1);
                        restart_pend     <= 1'b0;
                        o_i2c_enb        <= 1'b1;
                        o_lcr_enb        <= 1'b0;
                    end else begin
                        state  <= RUN;
                        o_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_codec_ctrl.sv
module tb_codec_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, vol_up, vol_dn, i2c_done;
    logic       i2c_enb, lcr_enb, busy, err;
    logic [6:0] addr, vol;
    logic [8:0] data;

    always #5 clk = ~clk;

    codec_ctrl dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_vol_up(vol_up), .i_vol_dn(vol_dn),
        .i_i2c_done(i2c_done), .o_i2c_enb(i2c_enb), .o_addr(addr), .o_data(data),
        .o_lcr_enb(lcr_enb), .o_busy(busy), .o_err(err), .o_vol(vol)
    );

    typedef struct {
        logic       up;
        logic       dn;
        logic       wr;
        logic [6:0] vol;
    } vec_t;

    vec_t        vecs[6];
    int          total = 0;
    int          bad = 0;
    logic [15:0] wr_q[$];
    int          hold_idx = -1;
    int          ack_delay = 100;
    int          hi_cnt = 0, last_hi = 0, low_run = 0, min_gap = 1000;
    bit          had_fall = 0;
    logic        enb_q = 1'b0;

    // I2C master model: acks each write after ack_delay high cycles unless held.
    initial begin
        i2c_done = 1'b0;
        forever begin
            @(negedge clk);
            i2c_done = 1'b0;
            if (i2c_enb && !enb_q) begin
                if (had_fall && low_run < min_gap) min_gap = low_run;
                wr_q.push_back({addr, data});
                hi_cnt = 0;
            end
            if (i2c_enb) begin
                hi_cnt++;
                if (hi_cnt == ack_delay && (wr_q.size() - 1) != hold_idx) i2c_done = 1'b1;
            end else begin
                if (enb_q) begin
                    last_hi  = hi_cnt;
                    had_fall = 1;
                    low_run  = 0;
                end
                low_run++;
            end
            enb_q = i2c_enb;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] exp_entry(input int i, input logic [6:0] v);
        logic [15:0] t[8];
        t[0] = {7'd15, 9'h000}; t[1] = {7'd6, 9'h010}; t[2] = {7'd4, 9'h012};
        t[3] = {7'd5, 9'h000};  t[4] = {7'd7, 9'h002}; t[5] = {7'd8, 9'h001};
        t[6] = {7'd2, 2'b10, v}; t[7] = {7'd9, 9'h001};
        return t[i];
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        wr_q.delete();
        min_gap  = 1000;
        had_fall = 0;
        hold_idx = -1;
    endtask

    // RUN must hold for 20 consecutive cycles so a one-cycle RUN between
    // back-to-back volume writes is not taken as settled.
    task automatic wait_run(input int budget);
        int stable = 0;
        int n = 0;
        while (stable < 20 && n < budget) begin
            @(negedge clk);
            n++;
            if (lcr_enb && !busy && !i2c_enb) stable++;
            else stable = 0;
        end
        check("run_reached", 32'(stable >= 20), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_vol(input logic u, input logic d);
        vol_up = u;
        vol_dn = d;
        @(negedge clk);
        vol_up = 1'b0;
        vol_dn = 1'b0;
    endtask

    initial begin
        logic [7:0] mv, nv;
        int         n;

        rst = 1'b1; start = 1'b0; vol_up = 1'b0; vol_dn = 1'b0;
        vecs[0] = '{1'b1, 1'b0, 1'b1, 7'h7D};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 7'h7F};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 7'h7F};
        vecs[3] = '{1'b1, 1'b1, 1'b0, 7'h7F};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 7'h7B};
        vecs[5] = '{1'b0, 1'b1, 1'b1, 7'h77};

        tick(3);
        check("rst_enb", 32'(i2c_enb), 32'd0);
        check("rst_lcr", 32'(lcr_enb), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_vol", 32'(vol), 32'h79);
        check("rst_addr", 32'(addr), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        clear_log();
        rst = 1'b0;
        tick(5);
        check("idle_enb", 32'(i2c_enb), 32'd0);

        // Full init sequence
        pulse_start();
        check("start_enb", 32'(i2c_enb), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        check("start_addr", 32'(addr), 32'd15);
        wait_run(3000);
        check("init_nwr", 32'(wr_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < wr_q.size(); i++)
            check($sformatf("init_wr%0d", i), 32'(wr_q[i]), 32'(exp_entry(i, 7'h79)));
        check("init_gap", 32'(min_gap), 32'd16);
        check("init_hi", 32'(last_hi), 32'd100);
        check("init_vol", 32'(vol), 32'h79);
        check("init_err", 32'(err), 32'd0);

        // Volume vectors from RUN
        for (int i = 0; i < 6; i++) begin
            clear_log();
            pulse_vol(vecs[i].up, vecs[i].dn);
            tick(3);
            wait_run(1000);
            check($sformatf("vec%0d_nwr", i), 32'(wr_q.size()), 32'(vecs[i].wr));
            if (vecs[i].wr && wr_q.size() > 0)
                check($sformatf("vec%0d_wr", i), 32'(wr_q[0]), 32'({7'd2, 2'b10, vecs[i].vol}));
            check($sformatf("vec%0d_vol", i), 32'(vol), 32'(vecs[i].vol));
        end

        // Two down requests during a volume write collapse to one further step
        clear_log();
        pulse_vol(1'b0, 1'b1);
        n = 0;
        while (!i2c_enb && n < 20) begin @(negedge clk); n++; end
        check("vreq_seen", 32'(i2c_enb), 32'd1);
        tick(5);
        pulse_vol(1'b0, 1'b1);
        tick(1);
        pulse_vol(1'b0, 1'b1);
        wait_run(2000);
        check("dbl_nwr", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() == 2) begin
            check("dbl_wr0", 32'(wr_q[0]), 32'({7'd2, 2'b10, 7'h73}));
            check("dbl_wr1", 32'(wr_q[1]), 32'({7'd2, 2'b10, 7'h6F}));
        end
        check("dbl_vol", 32'(vol), 32'h6F);

        // Walk down to the lower limit
        mv = 8'h6F;
        n = 0;
        while (mv != 8'h30 && n < 30) begin
            nv = (mv < 8'h34) ? 8'h30 : mv - 8'd4;
            pulse_vol(1'b0, 1'b1);
            tick(3);
            wait_run(1000);
            check($sformatf("down_%0h", nv), 32'(vol), 32'(nv));
            mv = nv;
            n++;
        end
        clear_log();
        pulse_vol(1'b0, 1'b1);
        tick(3);
        wait_run(1000);
        check("min_nwr", 32'(wr_q.size()), 32'd0);
        check("min_vol", 32'(vol), 32'h30);
        pulse_vol(1'b1, 1'b0);
        tick(3);
        wait_run(1000);
        check("min_up_vol", 32'(vol), 32'h34);

        // Restart from RUN, then async reset mid-write
        clear_log();
        pulse_start();
        check("rs_lcr", 32'(lcr_enb), 32'd0);
        check("rs_enb", 32'(i2c_enb), 32'd1);
        tick(150);
        check("mid_enb", 32'(i2c_enb), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_enb", 32'(i2c_enb), 32'd0);
        check("arst_vol", 32'(vol), 32'h79);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_lcr", 32'(lcr_enb), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(30);
        check("arst_idle", 32'(i2c_enb | busy), 32'd0);

        // Timeout on the third init write, then recovery
        clear_log();
        hold_idx = 2;
        pulse_start();
        n = 0;
        while (!err && n < 6000) begin @(negedge clk); n++; end
        check("to_err", 32'(err), 32'd1);
        check("to_enb", 32'(i2c_enb), 32'd0);
        check("to_busy", 32'(busy), 32'd0);
        check("to_hi", 32'(last_hi), 32'd4095);
        check("to_nwr", 32'(wr_q.size()), 32'd3);
        clear_log();
        pulse_start();
        check("rec_err", 32'(err), 32'd0);
        check("rec_addr", 32'(addr), 32'd15);
        tick(10);
        pulse_vol(1'b1, 1'b0);
        wait_run(3000);
        check("rec_nwr", 32'(wr_q.size()), 32'd9);
        if (wr_q.size() == 9) begin
            check("rec_wr0", 32'(wr_q[0]), 32'(exp_entry(0, 7'h79)));
            check("rec_wr6", 32'(wr_q[6]), 32'(exp_entry(6, 7'h79)));
            check("rec_wr8", 32'(wr_q[8]), 32'({7'd2, 2'b10, 7'h7D}));
        end
        check("rec_vol", 32'(vol), 32'h7D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
